// File: rtl/log2_share_pkg.sv
// Shared types and constants for the time-shared log2 sequencer.
// Holds the sequencer states, the datapath widths and the default requester count.
package log2_share_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int LOG2_IN_W       = 8;
   localparam int LOG2_OUT_W      = 3;
   localparam int DEFAULT_NUM_REQ = 4;

endpackage

// File: rtl/log2.sv
// Combinational floor-log2 of an 8-bit operand; zero maps to 0.
// No state, no handshake: result follows the operand in the same cycle.
module log2 (
   input  logic [7:0] number,
   output logic [2:0] log
);

   // Highest set bit wins because later iterations overwrite earlier ones.
   always_comb begin
      log = '0;
      for (int i = 0; i < 8; i++) begin
         if (number[i]) begin
            log = 3'(i);
         end
      end
   end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
// Zero latency; grant is one-hot or all zero, grant_idx is 0 when nothing is requested.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          any_req
);

   logic found;
   int   idx;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      idx       = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = IW'(idx);
         end
      end
      any_req = |req;
   end

endmodule

// File: rtl/log2_share_ctrl.sv
// Round-robin sequencer sharing one log2 unit among NUM_REQ clients; accept-to-response is 2 cycles.
// Requests are only accepted in IDLE; a stalled response (resp_ready low) holds the block and all requests.
module log2_share_ctrl
   import log2_share_pkg::*;
#(
   parameter int NUM_REQ = DEFAULT_NUM_REQ,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*LOG2_IN_W-1:0]   req_number,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic                           resp_valid,
   input  logic                           resp_ready,
   output logic [LOG2_OUT_W-1:0]          resp_log,
   output logic [ID_W-1:0]                resp_id,
   output logic                           resp_exact,
   output logic                           resp_zero,
   output logic                           busy
);

   state_t                  state;
   state_t                  state_nxt;
   logic [ID_W-1:0]         ptr;
   logic [ID_W-1:0]         id_reg;
   logic [LOG2_IN_W-1:0]    op_reg;
   logic [LOG2_IN_W-1:0]    op_sel;
   logic [LOG2_OUT_W-1:0]   log_val;
   logic [NUM_REQ-1:0]      grant;
   logic [ID_W-1:0]         grant_idx;
   logic                    any_req;
   logic                    accept;
   logic                    compute;
   logic                    op_exact;
   logic                    op_zero;

   rr_arbiter #(
      .N  (NUM_REQ),
      .IW (ID_W)
   ) u_arb (
      .req       (req_valid),
      .ptr       (ptr),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any_req   (any_req)
   );

   log2 u_log2 (
      .number (op_reg),
      .log    (log_val)
   );

   always_comb begin
      op_sel = req_number[int'(grant_idx)*LOG2_IN_W +: LOG2_IN_W];
   end

   always_comb begin
      op_zero  = (op_reg == '0);
      op_exact = !op_zero && ((op_reg & (op_reg - LOG2_IN_W'(1))) == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // rst gates the Mealy grant so no req_ready escapes while the block is held in reset.
   always_comb begin
      state_nxt = state;
      req_ready = '0;
      accept    = 1'b0;
      compute   = 1'b0;
      case (state)
         IDLE: begin
            if (any_req && !rst) begin
               req_ready = grant;
               accept    = 1'b1;
               state_nxt = CALC;
            end
         end
         CALC: begin
            compute   = 1'b1;
            state_nxt = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_reg     <= '0;
         id_reg     <= '0;
         ptr        <= '0;
         resp_log   <= '0;
         resp_exact <= 1'b0;
         resp_zero  <= 1'b0;
      end else begin
         if (accept) begin
            op_reg <= op_sel;
            id_reg <= grant_idx;
            if (grant_idx == ID_W'(NUM_REQ - 1)) begin
               ptr <= '0;
            end else begin
               ptr <= grant_idx + ID_W'(1);
            end
         end
         if (compute) begin
            resp_log   <= log_val;
            resp_exact <= op_exact;
            resp_zero  <= op_zero;
         end
      end
   end

   assign resp_valid = (state == RESP);
   assign resp_id    = id_reg;
   assign busy       = (state != IDLE);

   a_ready_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
   a_ready_needs_valid : assert property (@(posedge clk) disable iff (rst) ((req_ready & ~req_valid) == '0));

endmodule
